denoise_tile_scheduler: RTL
===========================

# denoise_tile_scheduler

Frame-level sequencer for the 3x3 denoise core. On a start pulse it walks the whole 638x482 frame in 3-row x 12-column output tiles. For each tile it fetches the five 14-pixel row segments of the 5x14 input window from the frame memory and packs them into the 560-bit window bus. It then hands the window to the filter core through a valid/ready handshake, tagged with its tile coordinates. It sits between the frame buffer and the core's `pixel_in` port and reports `done` once the last tile has been accepted.

## Interface
- `IMG_W`, 638: image width in pixels. Must satisfy (IMG_W-2) mod 12 = 0.
- `IMG_H`, 482: image height in pixels. Must satisfy (IMG_H-2) mod 3 = 0.
- `PIX_W`, 8: bits per pixel.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a frame. Ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the final window handshake.
- `mem_req` out 1: one-cycle read request for one row segment.
- `mem_row` out 9: image row of the request.
- `mem_col` out 10: column index of the segment's first (MSB) pixel. Pixels run col, col-1, …, col-13.
- `mem_rvalid` in 1: read data valid. Latency ≥1 cycle, variable.
- `mem_rdata` in 14*PIX_W: segment data, first pixel in the MSBs.
- `win_valid` out 1: window available.
- `win_ready` in 1: core accepts the window.
- `win_data` out 70*PIX_W: rows r..r+4 concatenated, row r in the MSBs.
- `tile_row` out 8: tile row index, 0..(IMG_H-2)/3-1.
- `tile_col` out 6: tile column index, 0..(IMG_W-2)/12-1.

## Operation
- FSM states: IDLE, REQ, WAIT, SEND, FIN.
- **IDLE → REQ** on `start`. Loads tile_row=0, tile_col=0, row offset k=0.
- **REQ**: asserts `mem_req` for exactly 1 cycle with `mem_row` = 3·tile_row + k and `mem_col` = IMG_W-1-12·tile_col. Goes to WAIT.
- **WAIT**: holds until `mem_rvalid`. Latches `mem_rdata` into window slot k (slot 0 in the MSBs).
  - If k<4: k++ and go to REQ.
  - Otherwise go to SEND.
  - `mem_rvalid` is ignored in every state except WAIT. Exactly one request is outstanding at any time.
- **SEND**: `win_valid`=1; `win_data`, `tile_row` and `tile_col` are stable. On `win_valid && win_ready`:
  - If this was the last tile (tile_row=Nr-1, tile_col=Nc-1): go to FIN.
  - Otherwise: tile_col++. At Nc-1, wrap tile_col to 0 and tile_row++. Set k=0 and go to REQ.
- **FIN**: `done`=1 for one cycle, `busy` drops, return to IDLE.
- Derived sizes: Nc = (IMG_W-2)/12, Nr = (IMG_H-2)/3. Defaults Nc=53, Nr=160, 8480 windows per frame.
- Tile order is raster: tile columns left to right (`mem_col` 637, 625, …, 13), then tile rows top to bottom (rows 0, 3, …, 477).
- Window rows overlap by 2 between vertically adjacent tiles. Segments are refetched, not cached.
- Reset values: all outputs 0 (`mem_row`, `mem_col`, `win_data` and the tile indices included), state IDLE, all counters 0.
- Reset asserted mid-frame aborts immediately. No `done` is produced, and a late `mem_rvalid` after reset is ignored because the block is in IDLE.
- `start` while busy has no effect. `start` in the same cycle as FIN's `done` is ignored; it is accepted from the following IDLE cycle.

## Timing
- `start` sampled high in IDLE: `mem_req` is high on the next cycle.
- Per tile with memory latency L (rvalid L cycles after `mem_req`): 5·(L+1) cycles of fetch, then `win_valid` in the next cycle.
- `win_ready` held high: handshake in the first SEND cycle, and the next `mem_req` follows 1 cycle later. Tile period = 5(L+1)+1 cycles; 31 cycles at L=5.
- Backpressure: `win_valid`, `win_data` and the tile indices hold unchanged while `win_ready`=0. `win_valid` never drops before the handshake.
- `done` is asserted the cycle after the final handshake. `busy` is low from the cycle after `done`.

## Test plan
- **Full frame, L=1, `win_ready`=1:**
  - Exactly 8480 windows, then one `done` pulse.
  - First requests are rows 0..4 at col 637; last requests are rows 477..481 at col 13.
  - `win_data` matches the bench model that packs 14-pixel segments of `pix/noise_638_482.txt`.
- **Small frame, IMG_W=26, IMG_H=8:** 4 windows, with (tile_row, tile_col, `mem_col`) = (0,0,25), (0,1,13), (1,0,25), (1,1,13), then `done`.
- **Random `win_ready` (30% high) and random L in 1..7:** no window lost or duplicated, and outputs stay stable while `win_valid`=1 and `win_ready`=0.
- **`start` pulsed during busy and stray `mem_rvalid` in SEND:** both ignored, and the window sequence is identical to the clean run.
- **Reset mid-fetch (k=2, 100th tile):** all outputs 0 in the cycle after reset, no `done`. A late `mem_rvalid` is ignored. A new `start` restarts at tile (0,0), row 0, col 637.
- **Back-to-back frames:** `start` on the cycle after `done` begins a second frame with identical output.

Source files
------------

// File: rtl/denoise_tile_scheduler.sv
// Frame sequencer for the 3x3 denoise core: walks the frame in 3x12 output
// tiles, fetches each 5x14 input window and hands it to the core.
module denoise_tile_scheduler #(
  parameter int IMG_W = 638,
  parameter int IMG_H = 482,
  parameter int PIX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_req,
  output logic [8:0]            mem_row,
  output logic [9:0]            mem_col,
  input  logic                  mem_rvalid,
  input  logic [14*PIX_W-1:0]   mem_rdata,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [70*PIX_W-1:0]   win_data,
  output logic [7:0]            tile_row,
  output logic [5:0]            tile_col
);

  localparam int NC    = (IMG_W - 2) / 12;
  localparam int NR    = (IMG_H - 2) / 3;
  localparam int SEG_W = 14 * PIX_W;
  localparam int WIN_W = 70 * PIX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SEND,
    S_FIN
  } state_t;

  state_t             r_state;
  logic [2:0]         r_k;
  logic               r_busy;
  logic               r_done;
  logic               r_mem_req;
  logic [8:0]         r_mem_row;
  logic [9:0]         r_mem_col;
  logic               r_win_valid;
  logic [WIN_W-1:0]   r_win;
  logic [7:0]         r_tile_row;
  logic [5:0]         r_tile_col;

  logic w_last_col;
  logic w_last_tile;

  assign w_last_col  = (r_tile_col == 6'(NC - 1));
  assign w_last_tile = w_last_col && (r_tile_row == 8'(NR - 1));

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_req   = r_mem_req;
  assign mem_row   = r_mem_row;
  assign mem_col   = r_mem_col;
  assign win_valid = r_win_valid;
  assign win_data  = r_win;
  assign tile_row  = r_tile_row;
  assign tile_col  = r_tile_col;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_row   <= '0;
      r_mem_col   <= '0;
      r_win_valid <= 1'b0;
      r_win       <= '0;
      r_tile_row  <= '0;
      r_tile_col  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_REQ;
            r_busy     <= 1'b1;
            r_mem_req  <= 1'b1;
            r_mem_row  <= '0;
            r_mem_col  <= 10'(IMG_W - 1);
            r_tile_row <= '0;
            r_tile_col <= '0;
            r_k        <= '0;
          end
        end
        S_REQ: begin
          r_mem_req <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            // Shift in: the first segment ends up in the MSBs after five loads
            r_win <= {r_win[WIN_W-SEG_W-1:0], mem_rdata};
            if (r_k != 3'd4) begin
              r_k       <= r_k + 3'd1;
              r_mem_row <= r_mem_row + 9'd1;
              r_mem_req <= 1'b1;
              r_state   <= S_REQ;
            end else begin
              r_win_valid <= 1'b1;
              r_state     <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (win_ready) begin
            r_win_valid <= 1'b0;
            if (w_last_tile) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_k       <= '0;
              r_mem_req <= 1'b1;
              r_state   <= S_REQ;
              // mem_row currently holds 3*tile_row+4
              if (w_last_col) begin
                r_tile_col <= '0;
                r_tile_row <= r_tile_row + 8'd1;
                r_mem_col  <= 10'(IMG_W - 1);
                r_mem_row  <= r_mem_row - 9'd1;
              end else begin
                r_tile_col <= r_tile_col + 6'd1;
                r_mem_col  <= r_mem_col - 10'd12;
                r_mem_row  <= r_mem_row - 9'd4;
              end
            end
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
